read_mem: RTL and testbench

READ_MEM -- requirements
Module: read_mem

---
 rtl/read_mem_pkg.sv | 14 +
 rtl/read_mem_skid_buf.sv | 61 ++++++
 rtl/read_mem.sv | 114 +++++++++++
 tb/tb_read_mem.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/read_mem_pkg.sv
// rtl/read_mem_pkg.sv - shared capture-buffer geometry and dump FSM encodings
package read_mem_pkg;

  localparam int RM_DATA_WIDTH  = 8;
  localparam int RM_ADDR_WIDTH  = 10;
  localparam int RM_MEMORY_SIZE = 2 ** RM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } rm_state_e;

endpackage

// File: rtl/read_mem_skid_buf.sv
// rtl/read_mem_skid_buf.sv - two-entry skid buffer absorbing the buffer read latency
module skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_tdata_i,
  input  logic             s_tvalid_i,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             pop;

  assign pop        = m_tvalid_o && m_tready_i;
  assign m_tdata_o  = head_q;
  assign m_tvalid_o = (count_q != 2'd0);
  assign count_o    = count_q;

  // The producer only pushes when a slot is guaranteed, so no overflow branch exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (s_tvalid_i) begin
            head_q  <= s_tdata_i;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          case ({s_tvalid_i, pop})
            2'b11: head_q <= s_tdata_i;
            2'b10: begin
              tail_q  <= s_tdata_i;
              count_q <= 2'd2;
            end
            2'b01: count_q <= 2'd0;
            default: ;
          endcase
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (s_tvalid_i) tail_q <= s_tdata_i;
            else            count_q <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/read_mem.sv
// rtl/read_mem.sv - dumps the circular capture buffer oldest-first as a ready/valid stream
module read_mem
  import read_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = RM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = RM_ADDR_WIDTH,
  parameter int MEMORY_SIZE = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  primed,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_LEN  = (ADDR_WIDTH + 1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0]   ONE_LEFT  = (ADDR_WIDTH + 1)'(1);

  rm_state_e               state_q;
  logic [ADDR_WIDTH:0]     remain_q;
  logic [ADDR_WIDTH:0]     len_d;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [ADDR_WIDTH-1:0]   start_addr_d;
  logic                    busy_q;
  logic                    done_q;
  logic                    rd_pend_q;
  logic                    rd_last_q;
  logic [1:0]              skid_count;
  logic [2:0]              occupancy;
  logic                    pop;
  logic [DATA_WIDTH:0]     skid_out;

  assign pop          = o_valid && o_ready;
  assign occupancy    = {1'b0, skid_count} + {2'b00, rd_pend_q};
  // A beat leaving this cycle frees a slot, which keeps 1 beat/cycle with o_ready high.
  assign rd_en        = (state_q == ST_STREAM) && (occupancy <= ({2'b00, pop} + 3'd1));
  assign len_d        = primed ? FULL_LEN : {1'b0, waddr};
  assign start_addr_d = primed ? waddr : '0;

  assign raddr  = raddr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign o_data = skid_out[DATA_WIDTH-1:0];
  assign o_last = skid_out[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      remain_q  <= '0;
      raddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= rd_en;
      rd_last_q <= rd_en && (remain_q == ONE_LEFT);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len_d == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= ST_STREAM;
              busy_q   <= 1'b1;
              raddr_q  <= start_addr_d;
              remain_q <= len_d;
            end
          end
        end
        ST_STREAM: begin
          if (rd_en) begin
            raddr_q  <= (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == ONE_LEFT) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && o_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .s_tdata_i  ({rd_last_q, rdata}),
    .s_tvalid_i (rd_pend_q),
    .m_tdata_o  (skid_out),
    .m_tvalid_o (o_valid),
    .m_tready_i (o_ready),
    .count_o    (skid_count)
  );

endmodule

// File: tb/tb_read_mem.sv
// tb/tb_read_mem.sv - self-checking bench for read_mem with an 8-entry capture buffer
module tb_read_mem;

  localparam int AW = 3;
  localparam int MS = 8;

  logic          clk = 1'b0;
  logic          reset, start, primed, rd_en, o_valid, o_ready, o_last, busy, done;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    rdata, o_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_mode = 0;
  int first_valid_cyc = -1;
  bit busy_seen = 0;
  bit stall_prev = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  logic [7:0] mem [MS];
  int bq[$];
  int lq[$];
  int cq[$];
  int dq[$];
  int dbq[$];

  typedef struct {
    logic          p;
    logic [AW-1:0] wa;
    int            mode;
    int            exp_len;
    int            exp_first;
    int            exp_final;
  } vec_t;
  vec_t tbl[6];

  read_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .MEMORY_SIZE(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .waddr(waddr), .primed(primed),
    .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .o_data(o_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_last(o_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rdata <= mem[raddr];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ~o_ready;
      default: o_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid && o_ready) begin
      bq.push_back(int'(o_data));
      lq.push_back(int'(o_last));
      cq.push_back(cyc);
    end
    if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) begin
      dq.push_back(cyc);
      dbq.push_back(int'(busy));
    end
    if (busy) busy_seen = 1;
    if (stall_prev && !reset) begin
      chk("stall_valid", int'(o_valid), 1);
      chk("stall_data", int'(o_data), int'(prev_data));
      chk("stall_last", int'(o_last), int'(prev_last));
    end
    stall_prev = o_valid && !o_ready;
    prev_data  = o_data;
    prev_last  = o_last;
  end

  task automatic clear_obs();
    bq.delete(); lq.delete(); cq.delete(); dq.delete(); dbq.delete();
    first_valid_cyc = -1;
    busy_seen = 0;
  endtask

  task automatic pulse_start(input logic p, input logic [AW-1:0] wa);
    @(posedge clk); #1;
    clear_obs();
    primed = p; waddr = wa; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    waddr = AW'($urandom);
    primed = 1'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dq.size() > 0) begin
        ok = 1;
        break;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_dump(input logic p, input logic [AW-1:0] wa, input bit ok, input bit lat);
    int m_len, m_start, n;
    m_len   = p ? MS : int'(wa);
    m_start = p ? int'(wa) : 0;
    chk("done_seen", int'(ok), 1);
    chk("beat_count", bq.size(), m_len);
    n = (bq.size() < m_len) ? bq.size() : m_len;
    for (int k = 0; k < n; k++) begin
      chk("beat_data", bq[k], int'(mem[(m_start + k) % MS]));
      chk("beat_last", lq[k], (k == m_len - 1) ? 1 : 0);
    end
    chk("done_pulses", dq.size(), 1);
    if (dq.size() > 0) chk("busy_at_done", dbq[0], 0);
    if (m_len == 0) begin
      chk("zero_busy", int'(busy_seen), 0);
      chk("zero_valid", first_valid_cyc, -1);
      if (dq.size() > 0) chk("zero_done_cycle", dq[0], start_cyc);
    end else begin
      if (dq.size() > 0 && cq.size() > 0) chk("done_after_last", dq[0], cq[$] + 1);
      if (lat) begin
        chk("first_latency", first_valid_cyc - start_cyc, 2);
        if (cq.size() > 0) chk("back_to_back", cq[$] - cq[0], m_len - 1);
      end
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; primed = 1'b0; waddr = '0; o_ready = 1'b1;
    for (int i = 0; i < MS; i++) mem[i] = 8'(i);
    tbl[0] = '{1'b0, 3'd5, 0, 5, 0, 4};
    tbl[1] = '{1'b1, 3'd3, 0, 8, 3, 2};
    tbl[2] = '{1'b1, 3'd0, 1, 8, 0, 7};
    tbl[3] = '{1'b0, 3'd0, 0, 0, 0, 0};
    tbl[4] = '{1'b0, 3'd1, 2, 1, 0, 0};
    tbl[5] = '{1'b1, 3'd7, 2, 8, 7, 6};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", int'({rd_en, raddr, o_data, o_valid, o_last, busy, done}), 0);

    foreach (tbl[t]) begin
      ready_mode = tbl[t].mode;
      pulse_start(tbl[t].p, tbl[t].wa);
      wait_done(ok);
      check_dump(tbl[t].p, tbl[t].wa, ok, tbl[t].mode == 0);
      chk("tbl_len", bq.size(), tbl[t].exp_len);
      if (tbl[t].exp_len > 0 && bq.size() > 0) begin
        chk("tbl_first", bq[0], tbl[t].exp_first);
        chk("tbl_final", bq[$], tbl[t].exp_final);
      end
    end

    // Reset in the middle of a dump, then a fresh full dump.
    ready_mode = 0;
    pulse_start(1'b1, 3'd2);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bq.size() >= 3) begin
        ok = 1;
        break;
      end
    end
    chk("mid_dump_reached", int'(ok), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_outputs", int'({rd_en, raddr, o_data, o_valid, o_last, busy, done}), 0);
    clear_obs();
    repeat (4) @(negedge clk);
    chk("abort_no_beats", bq.size(), 0);
    chk("abort_no_done", dq.size(), 0);
    pulse_start(1'b1, 3'd6);
    wait_done(ok);
    check_dump(1'b1, 3'd6, ok, 1'b1);

    // Extra start pulses with different snapshot inputs during a dump are ignored.
    ready_mode = 2;
    pulse_start(1'b1, 3'd1);
    repeat (2) @(posedge clk);
    #1 waddr = 3'd5; primed = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 waddr = 3'd4; primed = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(ok);
    check_dump(1'b1, 3'd1, ok, 1'b0);

    // Randomised dumps against the reference model.
    for (int r = 0; r < 12; r++) begin
      logic          rp;
      logic [AW-1:0] rw;
      for (int i = 0; i < MS; i++) mem[i] = 8'($urandom);
      rp = 1'($urandom);
      rw = AW'($urandom);
      ready_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      pulse_start(rp, rw);
      wait_done(ok);
      check_dump(rp, rw, ok, ready_mode == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
